// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit. It retires STEP bits per cycle through a
// shift-add multiplier or a restoring divider, and applies the sign fix on the last iteration.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | iterating, down-counter cnt holds the remaining iterations
// DONE  | result valid, held until out_ready
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int ITERS = WIDTH / STEP;
  localparam int CW    = $clog2(ITERS + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]         op;
  logic               neg_q, neg_a;
  logic [2*WIDTH-1:0] acc;   // mul: {product high, multiplier}; div: low half is dividend/quotient
  logic [WIDTH-1:0]   dvs;   // multiplicand or divisor magnitude
  logic [WIDTH:0]     rem;
  logic [CW-1:0]      cnt;

  logic               sa, sb, a_neg, b_neg, div_zero, ovf, fast, accept, last;
  logic [WIDTH-1:0]   mag_a, mag_b, fast_res;

  assign sa       = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign sb       = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = sa & op_a[WIDTH-1];
  assign b_neg    = sb & op_b[WIDTH-1];
  assign mag_a    = a_neg ? -op_a : op_a;
  assign mag_b    = b_neg ? -op_b : op_b;
  assign div_zero = (op_b == '0);
  assign ovf      = ((funct3 == 3'b100) || (funct3 == 3'b110)) &&
                    (op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (op_b == '1);
  assign fast     = funct3[2] & (div_zero | ovf);
  assign fast_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);
  assign accept   = (state == IDLE) && in_valid && !flush;
  assign last     = (cnt == CW'(1));

  // multiply step: add multiplicand times the low STEP multiplier bits, shift right by STEP
  logic [WIDTH+STEP-1:0] partial, msum;
  logic [2*WIDTH-1:0]    mul_nxt, prod;
  assign partial = {{STEP{1'b0}}, dvs} * {{WIDTH{1'b0}}, acc[STEP-1:0]};
  assign msum    = {{STEP{1'b0}}, acc[2*WIDTH-1:WIDTH]} + partial;
  assign mul_nxt = {msum, acc[WIDTH-1:STEP]};
  assign prod    = neg_q ? -mul_nxt : mul_nxt;

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q, quo, rmd, calc_res;
  always_comb begin
    r = rem;
    q = acc[WIDTH-1:0];
    for (int i = 0; i < STEP; i++) begin
      r = {r[WIDTH-1:0], q[WIDTH-1]};
      q = {q[WIDTH-2:0], 1'b0};
      if (r >= {1'b0, dvs}) begin
        r    = r - {1'b0, dvs};
        q[0] = 1'b1;
      end
    end
  end

  assign quo      = neg_q ? -q : q;
  assign rmd      = neg_a ? -r[WIDTH-1:0] : r[WIDTH-1:0];
  assign calc_res = op[2] ? (op[1] ? rmd : quo)
                          : ((op == 3'b000) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = fast ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_a  <= 1'b0;
      acc    <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op    <= funct3;
        neg_q <= a_neg ^ b_neg;
        neg_a <= a_neg;
        rem   <= '0;
        cnt   <= CW'(ITERS);
        if (funct3[2]) begin
          acc <= {{WIDTH{1'b0}}, mag_a};
          dvs <= mag_b;
        end else begin
          acc <= {{WIDTH{1'b0}}, mag_b};
          dvs <= mag_a;
        end
        if (fast) result <= fast_res;
      end else if (state == CALC && !flush) begin
        cnt <= cnt - CW'(1);
        acc <= op[2] ? {acc[2*WIDTH-1:WIDTH], q} : mul_nxt;
        rem <= r;
        if (last) result <= calc_res;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Iterative RV32M multiply/divide execution unit; the multi-cycle successor to the single-cycle ALU control decode.
- Takes funct3 and two operands through a valid/ready handshake and computes the result in WIDTH/STEP iterations.
- Holds the result under output backpressure.
- Sits beside the main ALU in the execute stage; the core stalls while busy is high.

Parameters:
- WIDTH, 32, operand and result width in bits; even, at least 4.
- STEP, 1, bits retired per iteration; must be 1 or 2, and WIDTH % STEP == 0.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- funct3  in  3  operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  in  WIDTH  rs1 value (multiplicand or dividend).
- op_b  in  WIDTH  rs2 value (multiplier or divisor).
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- result  out  WIDTH  final result.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, out_valid 0, result 0, busy 0, in_ready 1, iteration counter 0, all datapath registers 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - Accept on the edge where in_valid && in_ready && !flush.
  - Capture funct3, op_a, op_b; later input changes are ignored.
  - Signed operands (MUL*/DIV/REM per RV32M signedness) are converted to magnitudes; result sign is recorded.
  - Next state is CALC, or DONE for a fast-path case.
- Fast path (IDLE to DONE in one edge):
  - Divisor zero: DIV/DIVU give all ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a = most negative, op_b = all ones): DIV gives op_a; REM gives 0.
- CALC:
  - Runs exactly WIDTH/STEP cycles, counted by an internal down-counter.
  - Multiply: shift-add into a 2*WIDTH accumulator, STEP multiplier bits per cycle.
  - Divide: restoring division, STEP quotient bits per cycle, using a WIDTH+1-bit partial remainder.
  - On the last iteration, apply the sign fix:
    - Product is negated if the operand signs differ (MULHSU: only op_a is signed).
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - MUL selects product[WIDTH-1:0]; MULH/MULHSU/MULHU select product[2W-1:W].
  - The selected value is registered into result and the state moves to DONE.
- Latency from the acceptance edge to out_valid high: WIDTH/STEP + 1 edges normally; 1 edge on the fast path.
- DONE:
  - out_valid = 1; result is held stable until the handshake.
  - On an edge with out_ready: go to IDLE, clear out_valid; in_ready = 1 in the following cycle.
  - No new request is accepted in the same cycle as the handshake.
- flush: on any edge with flush high, go to IDLE and clear out_valid; no result is delivered. flush overrides in_valid and out_ready in the same cycle.
- result keeps its last value in IDLE (not cleared except by reset).
- Reset mid-CALC or mid-DONE: immediate return to the reset values, without waiting for a clock edge.
- Undefined funct3 cannot occur (3-bit field fully decoded).

Test Plan:
- MUL 7 × 0xFFFFFFFD (WIDTH=32, STEP=1) → result 0xFFFFFFEB; out_valid exactly 33 edges after acceptance; in_ready low throughout.
- High products:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - Repeat all with STEP=2: identical results, 17-edge latency.
- Division:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
  - REM 7 / 0xFFFFFFFE → 1.
- Corner cases:
  - DIV 5 / 0 → 0xFFFFFFFF and REM 5 / 0 → 5, out_valid 1 edge after acceptance.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: hold out_ready low 5 cycles after out_valid → result stable, busy 1, in_valid ignored; raise out_ready → IDLE next edge, new request accepted the cycle after.
- Abort and reset:
  - flush at CALC iteration 10 with in_valid also high → IDLE next edge, no out_valid, no acceptance.
  - Drop rst_n mid-CALC between edges → out_valid/busy 0 and in_ready 1 before the next edge.
